// File: rtl/cdc_handshake_tx.sv
// Source side of a toggle req/ack clock-domain crossing: captures a word, holds it
// on o_xfer_data, flips o_req, and waits for the synchronized echo on i_ack.
module cdc_handshake_tx #(
  parameter int DATA_WIDTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                   i_clock,
  input  logic                   i_reset_n,
  input  logic [DATA_WIDTH-1:0]  i_data,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic [DATA_WIDTH-1:0]  o_xfer_data,
  output logic                   o_req,
  input  logic                   i_ack,
  input  logic                   i_clear,
  output logic                   o_busy,
  output logic                   o_timeout,
  output logic [COUNT_WIDTH-1:0] o_xfer_count
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, WAIT, ERROR} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   req_q, req_d;
  logic                   ready_q, ready_d;
  logic                   busy_q, busy_d;
  logic                   timeout_q, timeout_d;
  logic [TW-1:0]          tmo_cnt_q, tmo_cnt_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   ack_s;

  assign ack_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d   = state_q;
    sync_d    = {sync_q[SYNC_STAGES-2:0], i_ack};
    data_d    = data_q;
    req_d     = req_q;
    ready_d   = ready_q;
    busy_d    = busy_q;
    timeout_d = timeout_q;
    tmo_cnt_d = tmo_cnt_q;
    count_d   = count_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          data_d    = i_data;
          req_d     = ~req_q;
          ready_d   = 1'b0;
          busy_d    = 1'b1;
          tmo_cnt_d = '0;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        // An arriving ack takes priority over a timeout on the same edge.
        if (ack_s == req_q) begin
          ready_d = 1'b1;
          busy_d  = 1'b0;
          count_d = count_q + 1'b1;
          state_d = IDLE;
        end else if (TIMEOUT_CYCLES > 0) begin
          if (tmo_cnt_q == TMO_LAST) begin
            busy_d    = 1'b0;
            timeout_d = 1'b1;
            state_d   = ERROR;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
          end
        end
      end
      ERROR: begin
        // Adopt the destination's parity so the next toggle is seen as new.
        if (i_clear) begin
          req_d     = ack_s;
          timeout_d = 1'b0;
          ready_d   = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state_q   <= IDLE;
      sync_q    <= '0;
      data_q    <= '0;
      req_q     <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      tmo_cnt_q <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      data_q    <= data_d;
      req_q     <= req_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      tmo_cnt_q <= tmo_cnt_d;
      count_q   <= count_d;
    end
  end

  assign o_ready      = ready_q;
  assign o_xfer_data  = data_q;
  assign o_req        = req_q;
  assign o_busy       = busy_q;
  assign o_timeout    = timeout_q;
  assign o_xfer_count = count_q;

endmodule

// File: doc/cdc_handshake_tx.md
Name: cdc_handshake_tx

Overview:
Source-side end of the two-clock data crossing: accepts a word in the local clock domain and presents it on a held-stable bus with a toggle request. It waits for the destination's toggle acknowledge, which is asynchronous and synchronized internally, before accepting the next word. Pairs with a destination-domain capture block that synchronizes o_req and echoes it back on i_ack. Includes an optional acknowledge timeout and a transfer counter for debug.

Parameters:
DATA_WIDTH, 8, width of the transferred word
SYNC_STAGES, 2, flops in the i_ack synchronizer chain (minimum 2)
TIMEOUT_CYCLES, 0, WAIT cycles before declaring timeout; 0 disables the timeout
COUNT_WIDTH, 16, width of the completed-transfer counter

Ports:
i_clock  input  1  local (source-domain) clock, all logic on the rising edge
i_reset_n  input  1  reset, synchronous, active-low
i_data  input  DATA_WIDTH  word to send
i_valid  input  1  i_data valid
o_ready  output  1  block can accept a word this cycle
o_xfer_data  output  DATA_WIDTH  crossing data bus, registered, stable while a transfer is pending
o_req  output  1  request toggle, registered, drives the destination synchronizer
i_ack  input  1  acknowledge toggle from the destination domain, asynchronous to i_clock
i_clear  input  1  exits the ERROR state
o_busy  output  1  transfer pending
o_timeout  output  1  sticky timeout flag
o_xfer_count  output  COUNT_WIDTH  completed transfers, wraps modulo 2^COUNT_WIDTH

Behaviour:
- Reset (edge with i_reset_n=0), applied in any state, including mid-transfer:
  - state=IDLE, o_ready=1, o_busy=0, o_req=0, o_xfer_data=0, o_timeout=0, o_xfer_count=0.
  - Synchronizer flops and timeout counter cleared to 0.
  - Destination must be reset in the same window; otherwise toggle parity is undefined.
- i_ack passes through a SYNC_STAGES flop chain; ack_s is the last stage. Only ack_s is used by any logic.
- States: IDLE, WAIT, ERROR.
- IDLE (o_ready=1, o_busy=0):
  - On an edge with i_valid=1: o_xfer_data<=i_data, o_req<=~o_req (same edge), o_ready<=0, o_busy<=1, timeout counter<=0, go to WAIT.
  - With i_valid=0, nothing changes.
- WAIT (o_ready=0, o_busy=1):
  - o_xfer_data and o_req are held; i_data and i_valid are ignored.
  - If ack_s==o_req: go to IDLE, o_ready<=1, o_busy<=0, o_xfer_count<=o_xfer_count+1 (wraps).
  - Else, if TIMEOUT_CYCLES>0, the counter increments. When the counter reaches TIMEOUT_CYCLES-1 with no match: go to ERROR, o_timeout<=1.
  - Ack match wins over timeout on the same edge.
- ERROR (o_ready=0, o_busy=0, o_timeout=1):
  - On i_clear=1: o_req<=ack_s (re-aligns parity), o_timeout<=0, go to IDLE with o_ready<=1.
  - The counter is unchanged on clear, and the abandoned word is not counted.
- Loopback latency (i_ack=o_req, SYNC_STAGES=S):
  - Accept at edge 0, o_ready high again after edge S+1.
  - Next accept is possible at edge S+2, so throughput is 1 word per S+2 cycles.
- o_xfer_data never changes while o_busy=1. The destination may sample it once synchronized o_req differs from its last value.
- Spurious i_ack toggles in IDLE are not tracked; the parity mismatch is resolved only through ERROR/i_clear.

Test Plan:
- Reset: hold i_reset_n=0 for 3 edges with i_valid=1 and random i_ack -> o_ready=1, o_req=0, o_xfer_data=0, o_busy=0, o_timeout=0, o_xfer_count=0.
- Single loopback transfer, S=2: i_data=8'hA5 with i_valid=1 for one cycle -> o_req goes 0→1 and o_xfer_data=A5 after edge 0; o_ready=0 for edges 1–3 and 1 after edge 3; o_xfer_count=1.
- Back-to-back: i_valid held high with data A5, 3C, FF -> accepts at edges 0, 4, 8; o_req toggles each time; o_xfer_count=3; no word dropped or duplicated.
- Delayed ack: destination model echoes o_req 10 cycles late, with i_data changing every cycle -> o_xfer_data stays at the captured value for the whole WAIT; o_ready is low until 10+S+1 cycles after accept.
- Timeout, TIMEOUT_CYCLES=16, i_ack stuck at 0 -> o_timeout=1 exactly 16 edges after accept; o_ready=0, count unchanged. Pulse i_clear -> o_req=0, o_ready=1; the next transfer completes normally.
- Reset mid-WAIT: accept 8'h5A, assert i_reset_n=0 two cycles later -> all outputs at reset values on the next edge. After release, a new transfer completes with o_xfer_count=1.
